// File: rtl/ram_arb_pkg.sv
// Shared definitions for the two-master RAM arbiter: master indices and count.
package ram_arb_pkg;
  localparam logic M_CORE    = 1'b0;
  localparam logic M_DBG     = 1'b1;
  localparam int   N_MASTERS = 2;
endpackage

// File: rtl/ram_arbiter_rr_arb2.sv
// Two-way round-robin arbiter. The winner of a conflict is the master not granted last time.
module rr_arb2
  import ram_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_MASTERS-1:0] req_i,
  output logic [N_MASTERS-1:0] gnt_o,
  output logic                 idx_o,
  output logic                 last_o
);

  logic last_d, last_q;
  logic idx;

  always_comb begin
    idx = M_CORE;
    if (req_i[M_CORE] && req_i[M_DBG]) idx = ~last_q;
    else if (req_i[M_DBG])             idx = M_DBG;
    gnt_o = 2'b00;
    if (|req_i) gnt_o[idx] = 1'b1;
    last_d = (|req_i) ? idx : last_q;
  end

  // Reset to M_DBG so that m0 wins the first conflict.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_q <= M_DBG;
    else     last_q <= last_d;
  end

  assign idx_o  = idx;
  assign last_o = last_q;

endmodule

// File: rtl/ram_arbiter.sv
// Shares one dual-port RAM between the core (m0) and debug (m1) masters.
// Write and read ports arbitrate independently; read responses return to the issuer.
module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rvalid,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_we,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rvalid,
  output logic [DW-1:0] m1_rdata,
  output logic          ram_wen,
  output logic [AW-1:0] ram_w_addr,
  output logic [DW-1:0] ram_w_data,
  output logic          ram_ren,
  output logic [AW-1:0] ram_r_addr,
  input  logic [DW-1:0] ram_r_data,
  output logic          dbg_last_w,
  output logic          dbg_last_r
);

  logic [N_MASTERS-1:0] w_req, r_req, w_gnt, r_gnt;
  logic                 w_idx, r_idx;
  logic                 rsel_d, rsel_q;
  logic                 rpend_d, rpend_q;

  assign w_req = {m1_req &  m1_we, m0_req &  m0_we};
  assign r_req = {m1_req & ~m1_we, m0_req & ~m0_we};

  rr_arb2 u_warb (
    .clk    (clk),
    .rst    (rst),
    .req_i  (w_req),
    .gnt_o  (w_gnt),
    .idx_o  (w_idx),
    .last_o (dbg_last_w)
  );

  rr_arb2 u_rarb (
    .clk    (clk),
    .rst    (rst),
    .req_i  (r_req),
    .gnt_o  (r_gnt),
    .idx_o  (r_idx),
    .last_o (dbg_last_r)
  );

  assign m0_gnt = w_gnt[M_CORE] | r_gnt[M_CORE];
  assign m1_gnt = w_gnt[M_DBG]  | r_gnt[M_DBG];

  // Idle arbiters report index M_CORE, so idle RAM buses carry m0's payload.
  assign ram_wen    = |w_gnt;
  assign ram_w_addr = (w_idx == M_DBG) ? m1_addr  : m0_addr;
  assign ram_w_data = (w_idx == M_DBG) ? m1_wdata : m0_wdata;
  assign ram_ren    = |r_gnt;
  assign ram_r_addr = (r_idx == M_DBG) ? m1_addr  : m0_addr;

  always_comb begin
    rpend_d = |r_gnt;
    rsel_d  = (|r_gnt) ? r_idx : rsel_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpend_q <= 1'b0;
      rsel_q  <= M_CORE;
    end else begin
      rpend_q <= rpend_d;
      rsel_q  <= rsel_d;
    end
  end

  assign m0_rvalid = rpend_q & (rsel_q == M_CORE);
  assign m1_rvalid = rpend_q & (rsel_q == M_DBG);
  assign m0_rdata  = ram_r_data;
  assign m1_rdata  = ram_r_data;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter with a behavioural dual-port RAM and a read-response scoreboard.
module tb_ram_arbiter;
  localparam int DW = 32;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic          ram_wen, ram_ren;
  logic [AW-1:0] ram_w_addr, ram_r_addr;
  logic [DW-1:0] ram_w_data;
  logic [DW-1:0] ram_r_data = '0;
  logic          dbg_last_w, dbg_last_r;

  int vectors = 0;
  int miscompares = 0;
  logic [DW:0] exp_q[$];   // {master, data}

  always #5 clk = ~clk;

  ram_arbiter #(.DW(DW), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .ram_wen(ram_wen), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
    .ram_ren(ram_ren), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data),
    .dbg_last_w(dbg_last_w), .dbg_last_r(dbg_last_r)
  );

  // RAM model: registered read, write-first bypass on same-address collision.
  logic [DW-1:0] mem [0:255];
  always @(posedge clk) begin
    if (ram_wen) mem[ram_w_addr[7:0]] <= ram_w_data;
    if (ram_ren)
      ram_r_data <= (ram_wen && ram_w_addr == ram_r_addr) ? ram_w_data : mem[ram_r_addr[7:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_m0(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d;
  endtask

  task automatic idle();
    set_m0(1'b0, 1'b0, '0, '0);
    set_m1(1'b0, 1'b0, '0, '0);
  endtask

  task automatic chk_gnt(input string tag, input logic g0, input logic g1);
    @(negedge clk);
    chk({tag, "_m0_gnt"}, 64'(m0_gnt), 64'(g0));
    chk({tag, "_m1_gnt"}, 64'(m1_gnt), 64'(g1));
  endtask

  // Called once per cycle after the edge: at most one read response is due.
  task automatic chk_resp(input string tag);
    logic [DW:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk({tag, "_m0_rvalid"}, 64'(m0_rvalid), 64'(e[DW] == 1'b0));
      chk({tag, "_m1_rvalid"}, 64'(m1_rvalid), 64'(e[DW] == 1'b1));
      chk({tag, "_rdata"}, 64'(e[DW] ? m1_rdata : m0_rdata), 64'(e[DW-1:0]));
    end else begin
      chk({tag, "_m0_rvalid_idle"}, 64'(m0_rvalid), 64'd0);
      chk({tag, "_m1_rvalid_idle"}, 64'(m1_rvalid), 64'd0);
    end
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick();
    chk("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
    chk("rst_m1_rvalid", 64'(m1_rvalid), 64'd0);
    rst = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    set_m1(1'b1, 1'b1, a, d);
    tick();
    idle();
  endtask

  initial begin
    // Reset state; grants stay combinational even while reset is held.
    tick();
    chk("rst_m0_rvalid0", 64'(m0_rvalid), 64'd0);
    chk("rst_m1_rvalid0", 64'(m1_rvalid), 64'd0);
    chk("rst_ram_wen", 64'(ram_wen), 64'd0);
    chk("rst_last_w", 64'(dbg_last_w), 64'd1);
    chk("rst_last_r", 64'(dbg_last_r), 64'd1);
    set_m0(1'b1, 1'b0, 32'h10, '0);
    chk_gnt("rst_comb", 1'b1, 1'b0);
    tick();
    chk("rst_no_rvalid", 64'(m0_rvalid), 64'd0);
    idle();
    rst = 1'b0;

    preload(32'h10, 32'hDEADBEEF);
    preload(32'h04, 32'h00000044);
    preload(32'h08, 32'h00000088);
    preload(32'h30, 32'h00003030);
    pulse_reset();

    // Single read by m0.
    set_m0(1'b1, 1'b0, 32'h10, '0);
    chk_gnt("rd1", 1'b1, 1'b0);
    chk("rd1_ren", 64'(ram_ren), 64'd1);
    chk("rd1_raddr", 64'(ram_r_addr), 64'h10);
    exp_q.push_back({1'b0, 32'hDEADBEEF});
    tick(); idle();
    chk_resp("rd1");

    // Read contention after reset: m0, m1, m0.
    pulse_reset();
    set_m0(1'b1, 1'b0, 32'h04, '0);
    set_m1(1'b1, 1'b0, 32'h08, '0);
    chk_gnt("rc0", 1'b1, 1'b0);
    chk("rc0_raddr", 64'(ram_r_addr), 64'h04);
    exp_q.push_back({1'b0, 32'h44});
    tick(); chk_resp("rc0");
    chk_gnt("rc1", 1'b0, 1'b1);
    chk("rc1_raddr", 64'(ram_r_addr), 64'h08);
    exp_q.push_back({1'b1, 32'h88});
    tick(); chk_resp("rc1");
    chk_gnt("rc2", 1'b1, 1'b0);
    exp_q.push_back({1'b0, 32'h44});
    tick(); idle(); chk_resp("rc2");

    // Parallel write (m0) and read (m1).
    set_m0(1'b1, 1'b1, 32'h20, 32'h1234);
    set_m1(1'b1, 1'b0, 32'h30, '0);
    chk_gnt("par", 1'b1, 1'b1);
    chk("par_wen", 64'(ram_wen), 64'd1);
    chk("par_ren", 64'(ram_ren), 64'd1);
    chk("par_waddr", 64'(ram_w_addr), 64'h20);
    chk("par_wdata", 64'(ram_w_data), 64'h1234);
    chk("par_raddr", 64'(ram_r_addr), 64'h30);
    exp_q.push_back({1'b1, 32'h3030});
    tick(); idle(); chk_resp("par");
    set_m0(1'b1, 1'b0, 32'h20, '0);
    chk_gnt("par_rb", 1'b1, 1'b0);
    exp_q.push_back({1'b0, 32'h1234});
    tick(); idle(); chk_resp("par_rb");

    // Same-address collision: m1 write, m0 read of 0x40.
    set_m0(1'b1, 1'b0, 32'h40, '0);
    set_m1(1'b1, 1'b1, 32'h40, 32'hA5A5A5A5);
    chk_gnt("col", 1'b1, 1'b1);
    exp_q.push_back({1'b0, 32'hA5A5A5A5});
    tick(); idle(); chk_resp("col");

    // Write contention on 0x50: m0 first, then m1.
    set_m0(1'b1, 1'b1, 32'h50, 32'h1);
    set_m1(1'b1, 1'b1, 32'h50, 32'h2);
    chk_gnt("wc0", 1'b1, 1'b0);
    chk("wc0_wdata", 64'(ram_w_data), 64'h1);
    tick(); chk_resp("wc0");
    chk_gnt("wc1", 1'b0, 1'b1);
    chk("wc1_wdata", 64'(ram_w_data), 64'h2);
    tick(); idle(); chk_resp("wc1");
    set_m0(1'b1, 1'b0, 32'h50, '0);
    chk_gnt("wc_rb", 1'b1, 1'b0);
    exp_q.push_back({1'b0, 32'h2});
    tick(); idle(); chk_resp("wc_rb");

    // Reset mid-read; a lone m0 write also leaves last_w pointing at m0.
    set_m1(1'b1, 1'b0, 32'h08, '0);
    set_m0(1'b1, 1'b1, 32'h60, 32'h7);
    chk_gnt("mr", 1'b1, 1'b1);
    tick(); idle();
    rst = 1'b1;
    #1;
    chk("mr_async_m1_rvalid", 64'(m1_rvalid), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_resp("mr_after");
    end
    set_m0(1'b1, 1'b1, 32'h70, 32'h11);
    set_m1(1'b1, 1'b1, 32'h70, 32'h22);
    chk_gnt("mr_wconf", 1'b1, 1'b0);
    tick(); idle();
    set_m0(1'b1, 1'b0, 32'h70, '0);
    set_m1(1'b1, 1'b0, 32'h08, '0);
    chk_gnt("mr_rconf", 1'b1, 1'b0);
    exp_q.push_back({1'b0, 32'h11});
    tick(); idle(); chk_resp("mr_rconf");

    chk("sb_empty", 64'(exp_q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
